// File: rtl/exec_stage_mc_if.sv
// exec_stage_mc_if: operand/result bundle between issue, execute, memory stage and NoC NI.
// Issue side: in_valid/in_ready plus rd1, rd2, pc, imm, radd, alu_src, alu_ctrl, ni_sel.
// Result side: out_valid/out_ready with alu_result, write_data, pc_target, radd_out, zero; NI side: ni_valid/ni_ready, ni_data.
// Modports: slave = execute stage, master = surrounding environment.
interface exec_stage_mc_if #(
  parameter int DATA_W = 32,
  parameter int RADD_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] imm;
  logic [RADD_W-1:0] radd;
  logic              alu_src;
  logic [3:0]        alu_ctrl;
  logic              ni_sel;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] pc_target;
  logic [RADD_W-1:0] radd_out;
  logic              zero;

  logic              ni_valid;
  logic              ni_ready;
  logic [DATA_W-1:0] ni_data;

  modport slave (
    input  in_valid, rd1, rd2, pc, imm, radd, alu_src, alu_ctrl, ni_sel, out_ready, ni_ready,
    output in_ready, out_valid, alu_result, write_data, pc_target, radd_out, zero, ni_valid, ni_data
  );

  modport master (
    output in_valid, rd1, rd2, pc, imm, radd, alu_src, alu_ctrl, ni_sel, out_ready, ni_ready,
    input  in_ready, out_valid, alu_result, write_data, pc_target, radd_out, zero, ni_valid, ni_data
  );
endinterface

// File: rtl/exec_stage_mc.sv
// exec_stage_mc: MIPS execute stage (ALU, branch target, optional iterative MUL/DIV/REM), results to memory stage or NoC NI.
// Latency: 1 edge for single-cycle ops; MUL/DIV/REM load DATA_W+1 edges after accept (only with EXEC_MULDIV_EN defined).
// Backpressure: in_ready only when FSM idle and both result registers free or draining; held results stay stable until taken.
// Ports: clk, rst_n (async active-low), bus (exec_stage_mc_if.slave: issue, memory-stage result and NI word channels).
// Build option: define EXEC_MULDIV_EN for multi-cycle codes 8-10; otherwise they return 0 in one cycle.
module exec_stage_mc #(
  parameter int DATA_W = 32,
  parameter int RADD_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  exec_stage_mc_if.slave bus
);
  localparam int SH_W = $clog2(DATA_W);

  // ---------------- single-cycle ALU and branch target ----------------
  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] pct_y;
  logic              slt;

  always_comb begin
    src_b = bus.alu_src ? bus.imm : bus.rd2;
    slt   = $signed(bus.rd1) < $signed(src_b);
    pct_y = bus.pc + (bus.imm << 2);
    alu_y = '0;
    case (bus.alu_ctrl)
      4'd0:    alu_y = bus.rd1 & src_b;
      4'd1:    alu_y = bus.rd1 | src_b;
      4'd2:    alu_y = bus.rd1 + src_b;
      4'd3:    alu_y = bus.rd1 ^ src_b;
      4'd4:    alu_y = bus.rd1 << src_b[SH_W-1:0];
      4'd5:    alu_y = bus.rd1 >> src_b[SH_W-1:0];
      4'd6:    alu_y = bus.rd1 - src_b;
      4'd7:    alu_y = {{(DATA_W-1){1'b0}}, slt};
      default: alu_y = '0;
    endcase
  end

  // ---------------- output registers ----------------
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [DATA_W-1:0] pc_target_q, pc_target_d;
  logic [RADD_W-1:0] radd_out_q, radd_out_d;
  logic              zero_q, zero_d;
  logic              ni_valid_q, ni_valid_d;
  logic [DATA_W-1:0] ni_data_q, ni_data_d;

  logic              idle, out_free, ni_free, in_ready_w, accept;
  logic              load_out, load_ni;
  logic [DATA_W-1:0] ld_res, ld_wd, ld_pct;
  logic [RADD_W-1:0] ld_radd;

`ifdef EXEC_MULDIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  state_t            state_q, state_d;
  logic [SH_W-1:0]   cnt_q, cnt_d;
  // acc: product / partial remainder; opa: multiplicand / dividend-then-quotient; opb: multiplier / divisor
  logic [DATA_W-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;
  logic [1:0]        md_op_q, md_op_d;   // alu_ctrl[1:0]: 0 MUL, 1 DIV, 2 REM
  logic              md_ni_q, md_ni_d;
  logic [DATA_W-1:0] md_wd_q, md_wd_d, md_pct_q, md_pct_d;
  logic [RADD_W-1:0] md_radd_q, md_radd_d;
  logic [DATA_W:0]   div_rs, div_diff;
  logic              is_md;
`endif

  always_comb begin
    out_free = !out_valid_q || bus.out_ready;
    ni_free  = !ni_valid_q || bus.ni_ready;
`ifdef EXEC_MULDIV_EN
    idle  = (state_q == IDLE);
    is_md = (bus.alu_ctrl >= 4'd8) && (bus.alu_ctrl <= 4'd10);
`else
    idle  = 1'b1;
`endif
    in_ready_w = idle && out_free && ni_free;
    accept     = bus.in_valid && in_ready_w;

    load_out = 1'b0;
    load_ni  = 1'b0;
    ld_res   = alu_y;
    ld_wd    = bus.rd2;
    ld_pct   = pct_y;
    ld_radd  = bus.radd;

`ifdef EXEC_MULDIV_EN
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    md_op_d   = md_op_q;
    md_ni_d   = md_ni_q;
    md_wd_d   = md_wd_q;
    md_pct_d  = md_pct_q;
    md_radd_d = md_radd_q;
    // Restoring step: shift next dividend bit into the partial remainder and try subtracting.
    // A zero divisor always "fits", which naturally yields all-ones quotient and remainder = dividend.
    div_rs    = {acc_q, opa_q[DATA_W-1]};
    div_diff  = div_rs - {1'b0, opb_q};

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_md) begin
            state_d   = BUSY;
            cnt_d     = '0;
            acc_d     = '0;
            opa_d     = bus.rd1;
            opb_d     = src_b;
            md_op_d   = bus.alu_ctrl[1:0];
            md_ni_d   = bus.ni_sel;
            md_wd_d   = bus.rd2;
            md_pct_d  = pct_y;
            md_radd_d = bus.radd;
          end else begin
            load_out = !bus.ni_sel;
            load_ni  = bus.ni_sel;
          end
        end
      end
      BUSY: begin
        if (md_op_q == 2'd0) begin
          if (opb_q[0]) acc_d = acc_q + opa_q;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end else if (!div_diff[DATA_W]) begin
          acc_d = div_diff[DATA_W-1:0];
          opa_d = {opa_q[DATA_W-2:0], 1'b1};
        end else begin
          acc_d = div_rs[DATA_W-1:0];
          opa_d = {opa_q[DATA_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SH_W'(DATA_W - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        ld_res  = (md_op_q == 2'd1) ? opa_q : acc_q;
        ld_wd   = md_wd_q;
        ld_pct  = md_pct_q;
        ld_radd = md_radd_q;
        // Wait here until the destination register can take the word.
        if (md_ni_q ? ni_free : out_free) begin
          load_out = !md_ni_q;
          load_ni  = md_ni_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`else
    if (accept) begin
      load_out = !bus.ni_sel;
      load_ni  = bus.ni_sel;
    end
`endif

    out_valid_d  = out_valid_q && !bus.out_ready;
    ni_valid_d   = ni_valid_q && !bus.ni_ready;
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    pc_target_d  = pc_target_q;
    radd_out_d   = radd_out_q;
    zero_d       = zero_q;
    ni_data_d    = ni_data_q;

    // A reload on the draining edge wins over the clear, keeping full throughput.
    if (load_out) begin
      out_valid_d  = 1'b1;
      alu_result_d = ld_res;
      zero_d       = (ld_res == '0);
      write_data_d = ld_wd;
      pc_target_d  = ld_pct;
      radd_out_d   = ld_radd;
    end
    if (load_ni) begin
      ni_valid_d = 1'b1;
      ni_data_d  = ld_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_target_q  <= '0;
      radd_out_q   <= '0;
      zero_q       <= 1'b0;
      ni_valid_q   <= 1'b0;
      ni_data_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_target_q  <= pc_target_d;
      radd_out_q   <= radd_out_d;
      zero_q       <= zero_d;
      ni_valid_q   <= ni_valid_d;
      ni_data_q    <= ni_data_d;
    end
  end

`ifdef EXEC_MULDIV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      md_op_q   <= '0;
      md_ni_q   <= 1'b0;
      md_wd_q   <= '0;
      md_pct_q  <= '0;
      md_radd_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      md_op_q   <= md_op_d;
      md_ni_q   <= md_ni_d;
      md_wd_q   <= md_wd_d;
      md_pct_q  <= md_pct_d;
      md_radd_q <= md_radd_d;
    end
  end
`endif

  assign bus.in_ready   = in_ready_w;
  assign bus.out_valid  = out_valid_q;
  assign bus.alu_result = alu_result_q;
  assign bus.write_data = write_data_q;
  assign bus.pc_target  = pc_target_q;
  assign bus.radd_out   = radd_out_q;
  assign bus.zero       = zero_q;
  assign bus.ni_valid   = ni_valid_q;
  assign bus.ni_data    = ni_data_q;
endmodule

// File: doc/exec_stage_mc.md
# exec_stage_mc

Parametrised, multi-cycle successor to the single-cycle MIPS execute stage. Performs ALU operations, computes the branch target, and registers results into an execute/memory output register with valid/ready handshakes. Adds an iterative multiply/divide unit that stalls the upstream stage. Routes results either to the memory stage or to the NoC network-interface port.

## Interface
Parameters:
- DATA_W, 32: datapath width (≥8, even).
- RADD_W, 5: destination register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands below are valid.
- in_ready  out  1  stage can accept; combinational.
- rd1, rd2  in  DATA_W  register-file operands.
- pc  in  DATA_W  PC of the instruction.
- imm  in  DATA_W  sign-extended immediate.
- radd  in  RADD_W  destination register address.
- alu_src  in  1  1: srcB=imm, 0: srcB=rd2.
- alu_ctrl  in  4  operation code.
- ni_sel  in  1  1: result goes to the NI port instead of the memory stage.
- out_valid  out  1  registered result valid toward the memory stage.
- out_ready  in  1  memory stage accepts.
- alu_result, write_data, pc_target  out  DATA_W  registered result, rd2, and branch target.
- radd_out  out  RADD_W  registered destination address.
- zero  out  1  registered (alu_result == 0).
- ni_valid  out  1  NI word valid.
- ni_ready  in  1  NI accepts.
- ni_data  out  DATA_W  NI word.

## Operation
- Accept on the clk edge where in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && (!ni_valid || ni_ready).
- alu_ctrl codes:
  - 0 AND; 1 OR; 2 ADD; 3 XOR.
  - 4 SLL and 5 SRL, shift amount srcB[log2(DATA_W)-1:0].
  - 6 SUB; 7 SLT (signed, result 0/1).
  - 8 MUL (low DATA_W bits, unsigned).
  - 9 DIV (unsigned quotient); 10 REM (unsigned remainder).
  - 11–15 give result 0.
- Arithmetic wraps modulo 2^DATA_W. No overflow flag.
- pc_target = pc + (imm << 2), truncated to DATA_W. It is computed and registered for every accepted op.
- Divide by zero: DIV gives all-ones, REM gives the dividend. No extra cycles.
- FSM states:
  - IDLE: codes 0–7 and 11–15 load the output register directly. Codes 8–10 latch operands and go to BUSY.
  - BUSY: one shift-add or restoring-divide step per cycle for DATA_W cycles (counter 0..DATA_W-1), then DONE.
  - DONE: load the output register; return to IDLE.
- Output routing:
  - ni_sel=0 loads alu_result, zero, write_data, radd_out, pc_target and sets out_valid.
  - ni_sel=1 loads ni_data, sets ni_valid, and leaves out_valid unchanged.
- Handshakes:
  - out_valid clears on out_valid && out_ready unless reloaded the same edge.
  - ni_valid clears on ni_valid && ni_ready unless reloaded the same edge.
  - Data is held stable while valid && !ready.
- Simultaneous drain and accept: both happen on the same edge, giving full throughput for single-cycle ops.

## Timing
- Reset (async assert) sets:
  - state=IDLE, counter=0.
  - out_valid=0, ni_valid=0.
  - alu_result, write_data, pc_target, ni_data = 0; radd_out=0; zero=0.
- in_ready=1 while rst_n is low or after release with nothing pending.
- Single-cycle latency: accepted at edge N gives valid after edge N.
- MUL/DIV/REM latency: accepted at edge N, BUSY for edges N+1..N+DATA_W, DONE loads at edge N+DATA_W+1. That is 33 cycles for DATA_W=32.
- in_ready is 0 throughout BUSY and DONE.
- Reset mid-BUSY aborts the operation. No result is produced.
- If the output register is still occupied at DONE, the FSM stays in DONE until the needed port drains, then loads on that edge.

## Configuration
- EXEC_MULDIV_EN defined: codes 8–10 are multi-cycle as above.
- EXEC_MULDIV_EN not defined:
  - No BUSY/DONE states, counter, or iterative datapath.
  - Codes 8–10 behave as 11–15 (single-cycle, result 0).

## Test plan
- Reset mid-stream: assert rst_n=0 with out_valid=1 and mid-BUSY. All outputs go 0 immediately and in_ready=1 after release.
- ADD back-to-back: rd1=5, imm=0xFFFFFFFB, alu_src=1, out_ready=1. alu_result=0 and zero=1 one cycle later. Next SUB 3-7 gives 0xFFFFFFFC, with no bubbles.
- Backpressure: out_ready=0 for 4 cycles after an OR result 0xF0F0. Data is held, in_ready=0, and the value transfers on the edge out_ready rises.
- MUL: 0x10000 × 0x10001 gives 0x00010000 exactly 33 cycles after accept, with in_ready=0 meanwhile. DIV 100/7 gives 14; REM gives 2.
- DIV by zero: 9/0 gives 0xFFFFFFFF; REM 9 by 0 gives 9.
- NI path: ni_sel=1, XOR 0xAA^0x55. ni_data=0xFF, ni_valid=1, out_valid stays 0, and ni_valid holds until ni_ready=1. With EXEC_MULDIV_EN undefined, MUL returns 0 in 1 cycle.
